aes_dec_stream_loader: RTL and testbench

Word-serial front/back end for the combinational AES decryption core. It collects a 128-bit ciphertext block from a 32-bit valid/ready stream and holds that block and a latched key stable on the core inputs. After a programmable settle window it captures the core's plaintext and streams it out as four 32-bit words. It sits directly upstream of the decryption core (driving its `encrypted`/`key` inputs) and consumes its `plaintext` output.

---
 rtl/aes_dec_stream_loader.sv | 170 +++++++++++++++++
 tb/tb_aes_dec_stream_loader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_stream_loader.sv
// aes_dec_stream_loader: word-serial wrapper around the combinational AES
// decryption core. Collects four 32-bit ciphertext words and holds them with a
// latched key on the core inputs. After SETTLE cycles it captures the core
// plaintext and streams it out as four 32-bit words, MSB word first.
//
// Optional feature macro: AES_DEC_LOADER_OVERLAP_EN. When it is defined, the
// next ciphertext block may be accepted while the current plaintext drains.
//
// Handshake rule for both streams: a word transfers on a rising edge where
// valid and ready are both high. Ready and valid come only from registered
// state (in_ready is also forced low while rst_n is low). Valid is never
// withdrawn, and data is held stable, until the transfer happens.
//
// Bit numbering follows the core: [0:N-1] with bit 0 the MSB, and word k
// occupies bits [32k +: 32].
module aes_dec_stream_loader #(
  parameter int NK     = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:32*NK-1]  key_in,
  input  logic              key_load,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [0:127]      core_ct,
  output logic [0:32*NK-1]  core_key,
  input  logic [0:127]      core_pt,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

`ifdef AES_DEC_LOADER_OVERLAP_EN
  // Extra bit lets the fill count saturate at 4 while the plaintext drains.
  localparam int FCW = 3;
`else
  localparam int FCW = 2;
`endif

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [FCW-1:0]      fill_q, fill_d;
  logic [3:0]          settle_q, settle_d;
  logic [1:0]          drain_q, drain_d;
  logic [0:127]        ct_q, ct_d;
  logic [0:127]        pt_q, pt_d;
  logic [0:32*NK-1]    key_q, key_d;

  logic                in_hs;
  logic                out_hs;
  logic [1:0]          fill_idx;

  // Output decode from registered state; in_ready is held low during reset.
  always_comb begin
    out_valid = (state_q == ST_DRAIN);
    busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
`ifdef AES_DEC_LOADER_OVERLAP_EN
    in_ready  = rst_n && ((state_q == ST_FILL) ||
                          ((state_q == ST_DRAIN) && (fill_q != 3'd4)));
`else
    in_ready  = rst_n && (state_q == ST_FILL);
`endif
    out_data  = out_valid ? pt_q[32*int'(drain_q) +: 32] : 32'h0;
    core_ct   = ct_q;
    core_key  = key_q;
    dbg_state = state_q;
  end

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign fill_idx = fill_q[1:0];

  // Next-state logic for the FSM, counters and data registers.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    ct_d     = ct_q;
    pt_d     = pt_q;
    key_d    = key_q;

    // Ciphertext words land wherever the fill count points, in any state
    // where in_ready is high.
    if (in_hs) begin
      ct_d[32*int'(fill_idx) +: 32] = in_data;
      fill_d = fill_q + FCW'(1);
    end

    // The key is frozen during WAIT so the core sees a stable key/ct pair.
    if (key_load && (state_q != ST_WAIT)) begin
      key_d = key_in;
    end

    case (state_q)
      ST_FILL: begin
        if (in_hs && (fill_q == FCW'(3))) begin
          fill_d   = '0;
          settle_d = SETTLE_LD;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (settle_q == 4'd0) begin
          pt_d    = core_pt;
          drain_d = 2'd0;
          state_d = ST_DRAIN;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (out_hs) begin
          drain_d = drain_q + 2'd1;
          if (drain_q == 2'd3) begin
`ifdef AES_DEC_LOADER_OVERLAP_EN
            // Use the updated count, so a 4th input word that arrives on the
            // same edge as the last output word still starts WAIT at once.
            if (fill_d == 3'd4) begin
              fill_d   = '0;
              settle_d = SETTLE_LD;
              state_d  = ST_WAIT;
            end else begin
              state_d = ST_FILL;
            end
`else
            state_d = ST_FILL;
`endif
          end
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State and data registers; reset discards any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FILL;
      fill_q   <= '0;
      settle_q <= 4'd0;
      drain_q  <= 2'd0;
      ct_q     <= '0;
      pt_q     <= '0;
      key_q    <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      settle_q <= settle_d;
      drain_q  <= drain_d;
      ct_q     <= ct_d;
      pt_q     <= pt_d;
      key_q    <= key_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_stream_loader.sv
// Testbench for aes_dec_stream_loader. A stand-in for the decryption core
// returns the FIPS-197 plaintext for the FIPS key/ciphertext pair and
// ~ct ^ key for anything else. Two extra instances (SETTLE = 1 and 15)
// share the stimulus for the settle-window test.
module tb_aes_dec_stream_loader;

  localparam int NK     = 4;
  localparam int SETTLE = 2;

  localparam logic [0:127] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] ONES     = {128{1'b1}};

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [0:127]      key_in = '0;
  logic              key_load = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready, out_valid, busy;
  logic [0:127]      core_ct, core_key, core_pt;
  logic [31:0]       out_data;
  logic [1:0]        dbg_state;

  logic              in_ready1, out_valid1, busy1;
  logic [0:127]      core_ct1, core_key1, core_pt1;
  logic [31:0]       out_data1;
  logic [1:0]        dbg_state1;

  logic              in_ready15, out_valid15, busy15;
  logic [0:127]      core_ct15, core_key15, core_pt15;
  logic [31:0]       out_data15;
  logic [1:0]        dbg_state15;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [0:127] fake_core(input logic [0:127] ct, input logic [0:127] k);
    if (ct == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
    return ~ct ^ k;
  endfunction

  assign core_pt   = fake_core(core_ct, core_key);
  assign core_pt1  = fake_core(core_ct1, core_key1);
  assign core_pt15 = fake_core(core_ct15, core_key15);

  aes_dec_stream_loader #(.NK(NK), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_ct(core_ct), .core_key(core_key), .core_pt(core_pt),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dbg_state(dbg_state));

  aes_dec_stream_loader #(.NK(NK), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .core_ct(core_ct1), .core_key(core_key1), .core_pt(core_pt1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .busy(busy1), .dbg_state(dbg_state1));

  aes_dec_stream_loader #(.NK(NK), .SETTLE(15)) u_s15 (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready15),
    .core_ct(core_ct15), .core_key(core_key15), .core_pt(core_pt15),
    .out_data(out_data15), .out_valid(out_valid15), .out_ready(out_ready),
    .busy(busy15), .dbg_state(dbg_state15));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [0:127] k);
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send_block(input logic [0:127] blk);
    int n;
    for (int w = 0; w < 4; w++) begin
      in_data  = blk[32*w +: 32];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
        tick();
        n++;
      end
      if (n >= 40) begin
        chk_cnt++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [0:127] pt);
    for (int w = 0; w < 4; w++) exp_q.push_back(pt[32*w +: 32]);
  endtask

  // Scoreboard side: pulls four words, optionally stalling on the first.
  task automatic recv_block(input int stall);
    int n;
    logic [31:0] e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!out_valid && n < 40) begin
        tick();
        n++;
      end
      if (i == 0 && stall > 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          chk_cnt++;
          if (out_valid !== 1'b1 || out_data !== exp_q[0])
            $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h",
                     out_valid, out_data, exp_q[0]);
          else pass_cnt++;
          tick();
        end
        out_ready = 1'b1;
      end
      e = exp_q.pop_front();
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== e)
        $display("FAIL out_word%0d: valid=%0b data=%h, required valid=1 data=%h",
                 i, out_valid, out_data, e);
      else pass_cnt++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    chk_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0 ||
        core_ct !== 128'h0 || core_key !== 128'h0)
      $display("FAIL reset_outputs: rdy/vld/busy=%b data=%h ct=%h key=%h, required all 0",
               {in_ready, out_valid, busy}, out_data, core_ct, core_key);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_settle_window();
    logic [0:127] blk = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    logic [0:127] ct0, ct1, ct15;
    int w0, w1, w15;
    logic ch0, ch1, ch15;
    w0 = 0; w1 = 0; w15 = 0; ch0 = 0; ch1 = 0; ch15 = 0;
    ct0 = '0; ct1 = '0; ct15 = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = blk[32*i +: 32];
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (busy && !out_valid) begin
        if (w0 == 0) ct0 = core_ct; else if (core_ct != ct0) ch0 = 1;
        w0++;
      end
      if (busy1 && !out_valid1) begin
        if (w1 == 0) ct1 = core_ct1; else if (core_ct1 != ct1) ch1 = 1;
        w1++;
      end
      if (busy15 && !out_valid15) begin
        if (w15 == 0) ct15 = core_ct15; else if (core_ct15 != ct15) ch15 = 1;
        w15++;
      end
      tick();
    end
    chk_cnt++;
    if (w1 !== 1) $display("FAIL wait_len_s1: %0d cycles, required 1", w1); else pass_cnt++;
    chk_cnt++;
    if (w15 !== 15) $display("FAIL wait_len_s15: %0d cycles, required 15", w15); else pass_cnt++;
    chk_cnt++;
    if (w0 !== SETTLE) $display("FAIL wait_len_main: %0d cycles, required %0d", w0, SETTLE);
    else pass_cnt++;
    chk_cnt++;
    if (ch1 || ch15 || ch0 || ct15 !== blk || ct1 !== blk)
      $display("FAIL ct_stable_wait: changed=%0b%0b%0b ct1=%h ct15=%h, required unchanged %h",
               ch0, ch1, ch15, ct1, ct15, blk);
    else pass_cnt++;
  endtask

  task automatic test_fips();
    int n;
    load_key(FIPS_KEY);
    push_exp(FIPS_PT);
    out_ready = 1'b1;
    send_block(FIPS_CT);
    chk_cnt++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL wait_entry: busy=%0b vld=%0b rdy=%0b, required 1 0 0", busy, out_valid, in_ready);
    else pass_cnt++;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (n !== SETTLE)
      $display("FAIL out_valid_latency: rose %0d cycles after T+1, required %0d", n, SETTLE);
    else pass_cnt++;
    recv_block(0);
    chk_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL back_to_fill: vld=%0b busy=%0b rdy=%0b, required 0 0 1", out_valid, busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    push_exp(FIPS_PT);
    send_block(FIPS_CT);
    recv_block(5);
  endtask

  task automatic test_key_in_wait();
    int n;
    push_exp(FIPS_PT);
    send_block(FIPS_CT);
    key_in = ONES;
    key_load = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      chk_cnt++;
      if (core_key !== FIPS_KEY)
        $display("FAIL key_frozen_wait: key=%h, required %h", core_key, FIPS_KEY);
      else pass_cnt++;
      tick();
      n++;
    end
    chk_cnt++;
    if (core_key !== FIPS_KEY)
      $display("FAIL key_first_drain: key=%h, required %h", core_key, FIPS_KEY);
    else pass_cnt++;
    tick();
    key_load = 1'b0;
    chk_cnt++;
    if (core_key !== ONES)
      $display("FAIL key_load_drain: key=%h, required %h", core_key, ONES);
    else pass_cnt++;
    recv_block(0);
    load_key(FIPS_KEY);
  endtask

  task automatic test_async_reset_mid_fill();
    logic [0:127] junk = 128'h11111111_22222222_33333333_44444444;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = junk[32*i +: 32];
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b000)
      $display("FAIL reset_immediate: rdy/vld/busy=%b, required 000", {in_ready, out_valid, busy});
    else pass_cnt++;
    chk_cnt++;
    if (core_ct !== 128'h0 || core_key !== 128'h0)
      $display("FAIL reset_regs: ct=%h key=%h, required 0 0", core_ct, core_key);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++;
    if (in_ready !== 1'b1 || core_ct !== 128'h0)
      $display("FAIL reset_after: rdy=%0b ct=%h, required 1 0", in_ready, core_ct);
    else pass_cnt++;
    load_key(FIPS_KEY);
    push_exp(FIPS_PT);
    send_block(FIPS_CT);
    chk_cnt++;
    if (core_ct !== FIPS_CT)
      $display("FAIL no_stale_ct: ct=%h, required %h", core_ct, FIPS_CT);
    else pass_cnt++;
    recv_block(0);
  endtask

  task automatic test_back_to_back();
    logic [0:127] blk_a = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
    logic [0:127] blk_b = 128'h13579bdf_2468ace0_fedcba98_76543210;
    logic [31:0]  words [8];
    int idx, outs, drain_in, bad_rdy;
    logic in_hs, out_hs, chk_next;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      words[i]   = blk_a[32*i +: 32];
      words[i+4] = blk_b[32*i +: 32];
    end
    push_exp(~blk_a ^ FIPS_KEY);
    push_exp(~blk_b ^ FIPS_KEY);
    idx = 0; outs = 0; drain_in = 0; bad_rdy = 0; chk_next = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && outs < 8; c++) begin
      in_valid = (idx < 8);
      in_data  = (idx < 8) ? words[idx] : 32'h0;
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_valid) begin
        if (in_ready) bad_rdy++;
        if (in_hs && outs < 4) drain_in++;
      end
      if (out_hs) begin
        e = exp_q.pop_front();
        chk_cnt++;
        if (out_data !== e)
          $display("FAIL b2b_word%0d: data=%h, required %h", outs, out_data, e);
        else pass_cnt++;
        outs++;
        chk_next = (outs == 4);
      end
      tick();
      if (in_hs) idx++;
      if (chk_next) begin
        chk_next = 1'b0;
        chk_cnt++;
`ifdef AES_DEC_LOADER_OVERLAP_EN
        if (busy !== 1'b1 || out_valid !== 1'b0)
          $display("FAIL b2b_next_wait: busy=%0b vld=%0b, required 1 0", busy, out_valid);
        else pass_cnt++;
`else
        if (busy !== 1'b0 || in_ready !== 1'b1)
          $display("FAIL b2b_next_fill: busy=%0b rdy=%0b, required 0 1", busy, in_ready);
        else pass_cnt++;
`endif
      end
    end
    in_valid = 1'b0;
    chk_cnt++;
    if (outs !== 8) $display("FAIL b2b_count: %0d words, required 8", outs); else pass_cnt++;
    chk_cnt++;
`ifdef AES_DEC_LOADER_OVERLAP_EN
    if (drain_in !== 4)
      $display("FAIL b2b_overlap_accept: %0d words in DRAIN, required 4", drain_in);
    else pass_cnt++;
`else
    if (bad_rdy !== 0)
      $display("FAIL b2b_ready_in_drain: in_ready high %0d DRAIN cycles, required 0", bad_rdy);
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_settle_window();
    test_fips();
    test_backpressure();
    test_key_in_wait();
    test_async_reset_mid_fill();
    test_back_to_back();
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
